// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: multi-cycle shift-add multiply/accumulate unit owning the HI/LO registers.
module hilo_mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [4:0]       ALUOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiWrite,
   input  logic             LoWrite,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);
   localparam logic [4:0] OP_MUL   = 5'd31;
   localparam logic [4:0] OP_MADD  = 5'd30;
   localparam logic [4:0] OP_MSUB  = 5'd29;
   localparam logic [4:0] OP_MULTU = 5'd26;
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, MULT, FIX, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0] mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
   logic [4:0] op_q, op_d;
   logic sign_q, sign_d;
   logic idle, valid, sgn_op;
   logic [WIDTH:0] sum;
   logic [2*WIDTH-1:0] pfix, acc;
   assign idle   = (state_q == IDLE) || (state_q == DONE);
   assign valid  = (ALUOp == OP_MUL) || (ALUOp == OP_MADD) || (ALUOp == OP_MSUB) || (ALUOp == OP_MULTU);
   assign sgn_op = ALUOp != OP_MULTU;
   // Multiplier lives in the low half of prod and is consumed one bit per shift.
   assign sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
   assign pfix = sign_q ? -prod_q : prod_q;
   assign acc  = {hi_q, lo_q};
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      mcand_d  = mcand_q;
      sign_d   = sign_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      case (state_q)
         MULT: begin
            prod_d  = {sum, prod_q[WIDTH-1:1]};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : MULT;
         end
         FIX: begin
            state_d = DONE;
            case (op_q)
               OP_MUL:   result_d = pfix[WIDTH-1:0];
               OP_MULTU: begin
                  {hi_d, lo_d} = pfix;
                  result_d     = pfix[WIDTH-1:0];
               end
               OP_MADD:  {hi_d, lo_d} = acc + pfix;
               default:  {hi_d, lo_d} = acc - pfix;
            endcase
         end
         default: begin
            state_d = IDLE;
            if (HiWrite) hi_d = A;
            if (LoWrite) lo_d = A;
            if (Start && valid) begin
               state_d = MULT;
               cnt_d   = '0;
               op_d    = ALUOp;
               mcand_d = (sgn_op && A[WIDTH-1]) ? -A : A;
               prod_d  = {{WIDTH{1'b0}}, ((sgn_op && B[WIDTH-1]) ? -B : B)};
               sign_d  = sgn_op && (A[WIDTH-1] ^ B[WIDTH-1]);
            end
         end
      endcase
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         prod_q   <= '0;
         mcand_q  <= '0;
         sign_q   <= 1'b0;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         sign_q   <= sign_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
      end
   end
   assign Busy   = (state_q == MULT) || (state_q == FIX);
   assign Done   = state_q == DONE;
   assign Result = result_q;
   assign HI     = hi_q;
   assign LO     = lo_q;
   wire unused_idle = idle;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb_hilo_mult_unit: directed vectors with hand-computed expectations for hilo_mult_unit.
module tb_hilo_mult_unit;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic Start = 1'b0;
   logic [4:0] ALUOp = '0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic HiWrite = 1'b0;
   logic LoWrite = 1'b0;
   logic Busy, Done;
   logic [31:0] Result, HI, LO;
   int n_cmp = 0;
   int n_bad = 0;
   hilo_mult_unit #(.WIDTH(32)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .ALUOp(ALUOp), .A(A), .B(B),
      .HiWrite(HiWrite), .LoWrite(LoWrite), .Busy(Busy), .Done(Done),
      .Result(Result), .HI(HI), .LO(LO)
   );
   always #5 Clk = ~Clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic wr(input logic hw, input logic lw, input logic [31:0] v);
      @(negedge Clk);
      HiWrite = hw;
      LoWrite = lw;
      A = v;
      @(negedge Clk);
      HiWrite = 1'b0;
      LoWrite = 1'b0;
   endtask
   task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      Start = 1'b1;
      ALUOp = op;
      A = a;
      B = b;
      @(negedge Clk);
      Start = 1'b0;
   endtask
   task automatic wait_done(output int k);
      k = 0;
      while (!Done && k < 100) begin
         @(negedge Clk);
         k++;
      end
      chk("done_seen", 64'(Done), 64'd1);
   endtask
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int k;
      start_op(op, a, b);
      wait_done(k);
      @(negedge Clk);
   endtask
   initial begin
      int k, nb, nd, kd;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      chk("rst_busy", 64'(Busy), 64'd0);
      chk("rst_done", 64'(Done), 64'd0);
      chk("rst_hilo", {HI, LO}, 64'd0);
      chk("rst_result", 64'(Result), 64'd0);
      // multu all-ones: latency and pulse shape
      start_op(5'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      nb = int'(Busy);
      nd = 0;
      kd = 0;
      for (int i = 2; i <= 40; i++) begin
         @(negedge Clk);
         nb += int'(Busy);
         if (Done) begin
            nd++;
            kd = i;
         end
      end
      chk("multu_busy_cycles", 64'(nb), 64'd33);
      chk("multu_done_pulses", 64'(nd), 64'd1);
      chk("multu_done_at", 64'(kd), 64'd34);
      chk("multu_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
      chk("multu_result", 64'(Result), 64'h1);
      // mul leaves HI/LO alone
      wr(1'b1, 1'b0, 32'h1111_1111);
      wr(1'b0, 1'b1, 32'h2222_2222);
      run_op(5'd31, 32'hFFFF_FFFD, 32'd5);
      chk("mul_result", 64'(Result), 64'hFFFF_FFF1);
      chk("mul_hilo", {HI, LO}, 64'h1111_1111_2222_2222);
      // MADD with negative product
      wr(1'b0, 1'b1, 32'h10);
      wr(1'b1, 1'b0, 32'h0);
      run_op(5'd30, 32'hFFFF_FFFE, 32'd3);
      chk("madd_hilo", {HI, LO}, 64'h0000_0000_0000_000A);
      chk("madd_result_held", 64'(Result), 64'hFFFF_FFF1);
      // MSUB wraps below zero
      wr(1'b1, 1'b1, 32'h0);
      run_op(5'd29, 32'd1, 32'd1);
      chk("msub_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFF);
      // most-negative operands
      wr(1'b1, 1'b1, 32'h0);
      run_op(5'd30, 32'h8000_0000, 32'h8000_0000);
      chk("madd_minneg", {HI, LO}, 64'h4000_0000_0000_0000);
      // invalid opcode ignored
      start_op(5'd2, 32'd9, 32'd9);
      chk("bad_op_busy", 64'(Busy), 64'd0);
      @(negedge Clk);
      chk("bad_op_hilo", {HI, LO}, 64'h4000_0000_0000_0000);
      // writes and restarts during MULT are ignored
      wr(1'b1, 1'b1, 32'd5);
      start_op(5'd31, 32'd3, 32'd4);
      repeat (4) @(negedge Clk);
      HiWrite = 1'b1;
      A = 32'hDEAD;
      Start = 1'b1;
      ALUOp = 5'd30;
      @(negedge Clk);
      HiWrite = 1'b0;
      Start = 1'b0;
      wait_done(k);
      chk("restart_ignored_at", 64'(k), 64'd28);
      chk("busy_write_ignored", {HI, LO}, 64'h0000_0005_0000_0005);
      chk("mul_small_result", 64'(Result), 64'd12);
      @(negedge Clk);
      // Start held through DONE: back-to-back accept
      Start = 1'b1;
      ALUOp = 5'd26;
      A = 32'd2;
      B = 32'd3;
      wait_done(k);
      chk("b2b_first_at", 64'(k), 64'd34);
      chk("b2b_first_lo", 64'(LO), 64'd6);
      A = 32'd5;
      B = 32'd7;
      @(negedge Clk);
      Start = 1'b0;
      chk("b2b_no_idle", 64'(Busy), 64'd1);
      wait_done(k);
      chk("b2b_second_at", 64'(k), 64'd33);
      chk("b2b_second_hilo", {HI, LO}, 64'd35);
      @(negedge Clk);
      // asynchronous reset mid-operation
      start_op(5'd26, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      chk("async_busy", 64'(Busy), 64'd0);
      chk("async_done", 64'(Done), 64'd0);
      chk("async_hilo", {HI, LO}, 64'd0);
      chk("async_result", 64'(Result), 64'd0);
      @(negedge Clk);
      Reset = 1'b0;
      nd = 0;
      repeat (40) begin
         @(negedge Clk);
         nd += int'(Done);
      end
      chk("no_done_after_reset", 64'(nd), 64'd0);
      run_op(5'd26, 32'd7, 32'd6);
      chk("post_reset_hilo", {HI, LO}, 64'd42);
      chk("post_reset_result", 64'(Result), 64'd42);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
